sync_edge_nch: RTL and testbench

Parametrised multi-channel synchroniser for asynchronous single-bit inputs: an N-stage flop chain per channel, optional per-channel glitch/debounce filter, rise/fall pulse generation and sticky, software-clearable event flags. Sits at the boundary between asynchronous sources (pads, foreign clock domains, slow status lines) and the `clk` domain logic and interrupt aggregation. It is the generalised successor of the two-stage rising-edge synchroniser.

---
 rtl/sync_pkg.sv | 18 +
 rtl/sync_edge_nch_if.sv | 40 ++++
 rtl/sync_ch_filt.sv | 91 +++++++++
 rtl/sync_edge_nch.sv | 78 +++++++
 tb/tb_sync_edge_nch.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared types and constants for the sync_edge_nch multi-channel synchroniser.
//   edge_sel_e      : encoding of the event source selector (none/rise/fall/both)
//   SYNC_STAGES_MIN : shallowest flop chain that still gives metastability margin
// -----------------------------------------------------------------------------
package sync_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_edge_nch_if.sv
// -----------------------------------------------------------------------------
// sync_edge_nch_if
// Bundles the data/control signals of sync_edge_nch.
//   sync_i     : CH asynchronous inputs
//   filt_len   : filter length, quasi-static, shared by all channels
//   edge_sel   : event source select (see sync_pkg::edge_sel_e)
//   evt_clr    : write-1-to-clear for evt_flag
//   sync_o     : synchronised (and optionally filtered) levels
//   rise_pulse : one-cycle pulse on sync_o 0->1
//   fall_pulse : one-cycle pulse on sync_o 1->0
//   evt_flag   : sticky event flags
//   evt_any    : OR of evt_flag
// Modports: master drives the inputs (system side), slave is the synchroniser.
// -----------------------------------------------------------------------------
interface sync_edge_nch_if #(
  parameter int CH     = 4,
  parameter int FILT_W = 4
);

  logic [CH-1:0]     sync_i;
  logic [FILT_W-1:0] filt_len;
  logic [1:0]        edge_sel;
  logic [CH-1:0]     evt_clr;
  logic [CH-1:0]     sync_o;
  logic [CH-1:0]     rise_pulse;
  logic [CH-1:0]     fall_pulse;
  logic [CH-1:0]     evt_flag;
  logic              evt_any;

  modport master (
    output sync_i, filt_len, edge_sel, evt_clr,
    input  sync_o, rise_pulse, fall_pulse, evt_flag, evt_any
  );

  modport slave (
    input  sync_i, filt_len, edge_sel, evt_clr,
    output sync_o, rise_pulse, fall_pulse, evt_flag, evt_any
  );

endinterface

// File: rtl/sync_ch_filt.sv
// -----------------------------------------------------------------------------
// sync_ch_filt
// One channel: STAGES-deep synchroniser chain, optional persistence filter
// (built when SYNC_EDGE_FILT_EN is defined) and edge detection.
//   clk        : clock, rising edge
//   rstn       : asynchronous active-low reset
//   async_i    : asynchronous input bit
//   filt_len_i : filter length (mismatch must persist filt_len_i+1 cycles)
//   level_o    : synchronised / filtered level
//   rise_o     : one-cycle pulse on level_o 0->1
//   fall_o     : one-cycle pulse on level_o 1->0
// -----------------------------------------------------------------------------
module sync_ch_filt #(
  parameter int   STAGES  = 2,
  parameter int   FILT_W  = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              async_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic              level_o,
  output logic              rise_o,
  output logic              fall_o
);

  logic [STAGES-1:0] stage_q;
  logic              raw;
  logic              level;
  logic              dly_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_q <= {STAGES{RST_VAL}};
    end else begin
      stage_q <= {stage_q[STAGES-2:0], async_i};
    end
  end

  assign raw = stage_q[STAGES-1];

`ifdef SYNC_EDGE_FILT_EN
  logic              level_q, level_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;

  // Commit on ">=" so a mid-count lowering of filt_len takes effect on the
  // next edge and the counter can never wrap.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (raw != level_q) begin
      if (cnt_q >= filt_len_i) begin
        level_d = raw;
      end else begin
        cnt_d = cnt_q + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
`else
  logic [FILT_W-1:0] unused_filt_len;
  assign unused_filt_len = filt_len_i;
  assign level           = raw;
`endif

  // Delayed copy resets to the same value as the level, so leaving reset
  // never produces an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dly_q <= RST_VAL;
    end else begin
      dly_q <= level;
    end
  end

  assign level_o = level;
  assign rise_o  = level & ~dly_q;
  assign fall_o  = ~level & dly_q;

endmodule

// File: rtl/sync_edge_nch.sv
// -----------------------------------------------------------------------------
// sync_edge_nch
// Parametrised multi-channel synchroniser with rise/fall pulses and sticky,
// software-clearable event flags.
// Optional feature macro: SYNC_EDGE_FILT_EN (per-channel persistence filter).
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : sync_edge_nch_if.slave (sync_i, filt_len, edge_sel, evt_clr in;
//          sync_o, rise_pulse, fall_pulse, evt_flag, evt_any out)
// -----------------------------------------------------------------------------
module sync_edge_nch
  import sync_pkg::*;
#(
  parameter int            CH      = 4,
  parameter int            STAGES  = 2,
  parameter int            FILT_W  = 4,
  parameter logic [CH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  sync_edge_nch_if.slave   bus
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_stages_chk
    $error("sync_edge_nch: STAGES must be at least %0d", SYNC_STAGES_MIN);
  end

  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    sync_ch_filt #(
      .STAGES  (STAGES),
      .FILT_W  (FILT_W),
      .RST_VAL (RST_VAL[gi])
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .async_i    (bus.sync_i[gi]),
      .filt_len_i (bus.filt_len),
      .level_o    (level[gi]),
      .rise_o     (rise[gi]),
      .fall_o     (fall[gi])
    );
  end

  edge_sel_e     sel;
  logic          sel_rise;
  logic          sel_fall;
  logic [CH-1:0] evt_set;
  logic [CH-1:0] evt_flag_q;
  logic [CH-1:0] evt_flag_d;

  assign sel      = edge_sel_e'(bus.edge_sel);
  assign sel_rise = (sel == EDGE_RISE) || (sel == EDGE_BOTH);
  assign sel_fall = (sel == EDGE_FALL) || (sel == EDGE_BOTH);
  assign evt_set  = ({CH{sel_rise}} & rise) | ({CH{sel_fall}} & fall);

  // A new event in the same cycle as its clear keeps the flag set, so no
  // event is lost to a racing software clear.
  assign evt_flag_d = evt_set | (evt_flag_q & ~bus.evt_clr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_flag_q <= '0;
    end else begin
      evt_flag_q <= evt_flag_d;
    end
  end

  assign bus.sync_o     = level;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.evt_flag   = evt_flag_q;
  assign bus.evt_any    = |evt_flag_q;

endmodule

// File: tb/tb_sync_edge_nch.sv
// -----------------------------------------------------------------------------
// tb_sync_edge_nch
// Directed + random stimulus for sync_edge_nch (CH=4, STAGES=3,
// RST_VAL=4'b1010). Expected outputs for every cycle are pushed to a
// scoreboard queue as inputs are driven and popped after the clock edge.
// Filter-specific steps are built only when SYNC_EDGE_FILT_EN is defined.
// -----------------------------------------------------------------------------
module tb_sync_edge_nch;
  import sync_pkg::*;

  localparam int            CH      = 4;
  localparam int            STAGES  = 3;
  localparam int            FILT_W  = 4;
  localparam logic [CH-1:0] RST_VAL = 4'b1010;
`ifdef SYNC_EDGE_FILT_EN
  localparam int LAT = STAGES;      // filt_len = 0 adds one cycle
`else
  localparam int LAT = STAGES - 1;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sync_edge_nch_if #(.CH(CH), .FILT_W(FILT_W)) bus ();

  sync_edge_nch #(
    .CH      (CH),
    .STAGES  (STAGES),
    .FILT_W  (FILT_W),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [CH-1:0] lvl;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] flag;
    logic          any;
  } exp_t;

  exp_t          sb_q[$];
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_lvl, m_prev, m_flag;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_model();
    hist.delete();
    sb_q.delete();
    for (int i = 0; i < LAT; i++) hist.push_back(RST_VAL);
    m_lvl  = RST_VAL;
    m_prev = RST_VAL;
    m_flag = '0;
  endtask

  // Drive one cycle of inputs (called at negedge), predict the outputs after
  // the next rising edge, then pop and compare them.
  task automatic drive_cycle(input logic [CH-1:0] in, input edge_sel_e sel,
                             input logic [CH-1:0] clr);
    exp_t          e, got;
    logic [CH-1:0] set;
    bus.sync_i   = in;
    bus.edge_sel = sel;
    bus.evt_clr  = clr;
    set = '0;
    if (sel == EDGE_RISE || sel == EDGE_BOTH) set |= m_lvl & ~m_prev;
    if (sel == EDGE_FALL || sel == EDGE_BOTH) set |= ~m_lvl & m_prev;
    m_flag = set | (m_flag & ~clr);
    hist.push_back(in);
    m_prev = m_lvl;
    m_lvl  = hist.pop_front();
    e.lvl  = m_lvl;
    e.rise = m_lvl & ~m_prev;
    e.fall = ~m_lvl & m_prev;
    e.flag = m_flag;
    e.any  = |m_flag;
    sb_q.push_back(e);
    tick();
    cyc++;
    got = sb_q.pop_front();
    $display("cyc %0d in=%b sel=%b clr=%b sync_o=%b rise=%b fall=%b flag=%b any=%b",
             cyc, in, sel, clr, bus.sync_o, bus.rise_pulse, bus.fall_pulse,
             bus.evt_flag, bus.evt_any);
    chk("sync_o",     bus.sync_o,     got.lvl);
    chk("rise_pulse", bus.rise_pulse, got.rise);
    chk("fall_pulse", bus.fall_pulse, got.fall);
    chk("evt_flag",   bus.evt_flag,   got.flag);
    chk("evt_any",    CH'(bus.evt_any), CH'(got.any));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] v;
    int            cnt;

    bus.sync_i   = RST_VAL;
    bus.filt_len = '0;
    bus.edge_sel = EDGE_BOTH;
    bus.evt_clr  = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_sync_o", bus.sync_o,     RST_VAL);
    chk("rst_rise",   bus.rise_pulse, '0);
    chk("rst_fall",   bus.fall_pulse, '0);
    chk("rst_flag",   bus.evt_flag,   '0);
    chk("rst_any",    CH'(bus.evt_any), '0);
    rstn = 1'b1;
    reset_model();

    // Held at RST_VAL: no spurious pulses or flags
    repeat (20) drive_cycle(RST_VAL, EDGE_BOTH, '0);

    // Latency: bit0 0->1 before edge k, sync_o[0] rises after edge k+2
    v = RST_VAL | 4'b0001;
    drive_cycle(v, EDGE_BOTH, '0);
    drive_cycle(v, EDGE_BOTH, '0);
    chk("lat_k1_sync0", CH'(bus.sync_o[0]), '0);
    drive_cycle(v, EDGE_BOTH, '0);
    chk("lat_k2_sync0", CH'(bus.sync_o[0]), CH'(1));
    chk("lat_k2_rise0", CH'(bus.rise_pulse[0]), CH'(1));
    drive_cycle(v, EDGE_BOTH, '0);
    chk("lat_k3_rise0", CH'(bus.rise_pulse[0]), '0);
    chk("lat_k3_flag0", CH'(bus.evt_flag[0]), CH'(1));

    // Toggle bit1 1->0->1 with both edges selected
    drive_cycle(v & 4'b1101, EDGE_BOTH, '0);
    repeat (4) drive_cycle(v & 4'b1101, EDGE_BOTH, '0);
    drive_cycle(v, EDGE_BOTH, '0);
    repeat (4) drive_cycle(v, EDGE_BOTH, '0);

    // Clear everything, then a clear coincident with a new rise on bit2
    drive_cycle(v, EDGE_BOTH, 4'b1111);
    chk("clr_all_flag", bus.evt_flag, '0);
    v = v | 4'b0100;
    drive_cycle(v, EDGE_BOTH, '0);
    drive_cycle(v, EDGE_BOTH, '0);
    drive_cycle(v, EDGE_BOTH, '0);
    chk("race_rise2", CH'(bus.rise_pulse[2]), CH'(1));
    drive_cycle(v, EDGE_BOTH, 4'b0100);
    chk("race_flag2", CH'(bus.evt_flag[2]), CH'(1));
    chk("race_any",   CH'(bus.evt_any), CH'(1));

    // Selector NONE: flags hold; then RISE-only and FALL-only
    repeat (6) drive_cycle(~v, EDGE_NONE, '0);
    repeat (6) drive_cycle(v, EDGE_RISE, 4'b1111);
    repeat (6) drive_cycle(~v, EDGE_FALL, 4'b0011);

    // Random stretch
    for (int i = 0; i < 60; i++) begin
      drive_cycle(CH'($urandom), edge_sel_e'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0);
    end

    // Make sure flags are set, then reset asynchronously mid-operation
    repeat (4) drive_cycle(4'b0000, EDGE_BOTH, '0);
    repeat (4) drive_cycle(4'b1111, EDGE_BOTH, '0);
    chk("pre_rst_flag", bus.evt_flag, 4'b1111);
    rstn = 1'b0;
    #1;
    chk("arst_flag",   bus.evt_flag,   '0);
    chk("arst_any",    CH'(bus.evt_any), '0);
    chk("arst_sync_o", bus.sync_o,     RST_VAL);
    chk("arst_rise",   bus.rise_pulse, '0);
    chk("arst_fall",   bus.fall_pulse, '0);
    bus.sync_i = RST_VAL;
    tick();
    tick();
    rstn = 1'b1;
    reset_model();
    repeat (8) drive_cycle(RST_VAL, EDGE_BOTH, '0);

`ifdef SYNC_EDGE_FILT_EN
    // 3-cycle glitch with filt_len=3 is discarded
    bus.filt_len = 4'd3;
    bus.sync_i   = RST_VAL | 4'b0001;
    repeat (3) tick();
    bus.sync_i = RST_VAL;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.sync_o[0] || bus.rise_pulse[0]) cnt++;
    end
    chk("filt_glitch", CH'(cnt), '0);

    // Persistent level commits after edge k+STAGES+3
    bus.sync_i = RST_VAL | 4'b0001;
    repeat (6) tick();
    chk("filt_k5_sync0", CH'(bus.sync_o[0]), '0);
    tick();
    chk("filt_k6_sync0", CH'(bus.sync_o[0]), CH'(1));
    chk("filt_k6_rise0", CH'(bus.rise_pulse[0]), CH'(1));

    // filt_len lowered 7->1 with cnt=5 commits on next edge
    bus.filt_len = 4'd7;
    bus.sync_i   = RST_VAL;
    repeat (8) tick();
    chk("lower_k7_sync0", CH'(bus.sync_o[0]), CH'(1));
    bus.filt_len = 4'd1;
    tick();
    chk("lower_k8_sync0", CH'(bus.sync_o[0]), '0);
    chk("lower_k8_fall0", CH'(bus.fall_pulse[0]), CH'(1));

    // Reset in the middle of a count with a flag set
    bus.filt_len = 4'd7;
    bus.sync_i   = RST_VAL | 4'b0001;
    repeat (6) tick();
    chk("mid_flag0", CH'(bus.evt_flag[0]), CH'(1));
    rstn = 1'b0;
    #1;
    chk("mid_arst_flag", bus.evt_flag, '0);
    chk("mid_arst_sync", bus.sync_o,   RST_VAL);
    bus.sync_i = RST_VAL;
    tick();
    rstn = 1'b1;
    cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if ((bus.rise_pulse | bus.fall_pulse) != '0) cnt++;
    end
    chk("mid_no_pulse", CH'(cnt), '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
